card_player_agent: RTL and testbench

//  Player side of the card-deal handshake. Requests cards from the dealer, accepts one card per

---
 rtl/card_player_agent.sv | 203 ++++++++++++++++++++
 tb/tb_card_player_agent.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_player_agent.sv
// card_player_agent
//   Player side of the card-deal handshake. The player raises cardReq, takes
//   one card per transfer edge (cardReq & cardReady), and keeps a best-hand
//   total in which an Ace counts 11 whenever that does not push the hand over
//   21. The hand ends by standing at STAND_AT, busting above 21, or running
//   out of card slots at MAX_CARDS.
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset        in   asynchronous active-high clear, returns to IDLE
//   new_Game     in   synchronous start/restart of a round (wins over a transfer)
//   cardReady    in   dealer presents cardValue4/color2
//   cardValue4   in   rank 1..13 (A, 2..10, J/Q/K); 0, 14, 15 are invalid
//   color2       in   suit of the presented card
//   cardReq      out  player wants a card
//   cardAck      out  one-cycle pulse in the cycle after a transfer edge
//   badCard      out  pulses together with cardAck for an invalid rank
//   totalValue5  out  best total, saturated at 31
//   cardCount3   out  valid cards in the hand
//   lastColor2   out  suit of the most recent valid card
//   finish       out  hand complete, held until new_Game or reset
//   stand        out  finished by reaching STAND_AT without busting
//   bust         out  finished with a total above 21
//
// Timing of one valid card: the transfer edge enters ADD (cardAck high),
// the next edge folds the card into the hand and enters DECIDE, and the edge
// after that either re-raises cardReq or ends the hand. An invalid card goes
// straight from ADD back to REQ.

module card_player_agent #(
  parameter int unsigned STAND_AT  = 17,
  parameter int unsigned MAX_CARDS = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       new_Game,
  input  logic       cardReady,
  input  logic [3:0] cardValue4,
  input  logic [1:0] color2,
  output logic       cardReq,
  output logic       cardAck,
  output logic       badCard,
  output logic [4:0] totalValue5,
  output logic [2:0] cardCount3,
  output logic [1:0] lastColor2,
  output logic       finish,
  output logic       stand,
  output logic       bust
);

  localparam logic [5:0] standAt6  = 6'(STAND_AT);
  localparam logic [2:0] maxCards3 = 3'(MAX_CARDS);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADD,
    DECIDE,
    DONE
  } playerState_t;

  playerState_t state;

  // Card captured on the transfer edge; the dealer may change its bus
  // afterwards, so ADD works from this copy.
  logic [3:0] latchedRank;
  logic [1:0] latchedColor;

  // Hand value with every Ace counted as 1; the soft bonus is applied on top.
  // A hand stops growing as soon as it exceeds 21, so the sum never gets
  // anywhere near the 6-bit limit.
  logic [5:0] hardSum6;
  logic       hasAce;

  function automatic logic rankValid(input logic [3:0] rank);
    return (rank != 4'd0) && (rank <= 4'd13);
  endfunction

  // Face cards count 10; Ace counts 1 here.
  function automatic logic [3:0] cardPoints(input logic [3:0] rank);
    return (rank >= 4'd10) ? 4'd10 : rank;
  endfunction

  // One Ace may be promoted to 11 as long as the hand stays at or below 21.
  function automatic logic [5:0] bestOf(input logic [5:0] hard, input logic ace);
    return (ace && (hard <= 6'd11)) ? hard + 6'd10 : hard;
  endfunction

  function automatic logic [4:0] sat31(input logic [5:0] v);
    return (v > 6'd31) ? 5'd31 : v[4:0];
  endfunction

  // Values the hand takes once the latched card is folded in.
  logic [5:0] addSum;
  logic       addAce;
  logic [5:0] bestNow;

  always_comb begin
    addSum  = hardSum6 + {2'b00, cardPoints(latchedRank)};
    addAce  = hasAce | (latchedRank == 4'd1);
    bestNow = bestOf(hardSum6, hasAce);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      latchedRank  <= 4'd0;
      latchedColor <= 2'd0;
      hardSum6     <= 6'd0;
      hasAce       <= 1'b0;
      cardReq      <= 1'b0;
      cardAck      <= 1'b0;
      badCard      <= 1'b0;
      totalValue5  <= 5'd0;
      cardCount3   <= 3'd0;
      lastColor2   <= 2'd0;
      finish       <= 1'b0;
      stand        <= 1'b0;
      bust         <= 1'b0;
    end else if (new_Game) begin
      // Restart from any state; a card offered on this same edge is dropped.
      // lastColor2 is left alone: it reports the last valid card seen.
      state       <= REQ;
      hardSum6    <= 6'd0;
      hasAce      <= 1'b0;
      cardReq     <= 1'b1;
      cardAck     <= 1'b0;
      badCard     <= 1'b0;
      totalValue5 <= 5'd0;
      cardCount3  <= 3'd0;
      finish      <= 1'b0;
      stand       <= 1'b0;
      bust        <= 1'b0;
    end else begin
      // Acknowledge flags are single-cycle pulses.
      cardAck <= 1'b0;
      badCard <= 1'b0;

      case (state)
        IDLE: begin
          cardReq <= 1'b0;
        end

        REQ: begin
          // cardReq is high throughout REQ, so cardReady alone marks a transfer.
          if (cardReady) begin
            latchedRank  <= cardValue4;
            latchedColor <= color2;
            cardReq      <= 1'b0;
            cardAck      <= 1'b1;
            badCard      <= ~rankValid(cardValue4);
            state        <= ADD;
          end
        end

        ADD: begin
          if (!rankValid(latchedRank)) begin
            cardReq <= 1'b1;
            state   <= REQ;
          end else begin
            hardSum6    <= addSum;
            hasAce      <= addAce;
            totalValue5 <= sat31(bestOf(addSum, addAce));
            cardCount3  <= cardCount3 + 3'd1;
            lastColor2  <= latchedColor;
            state       <= DECIDE;
          end
        end

        DECIDE: begin
          if (bestNow > 6'd21) begin
            bust   <= 1'b1;
            finish <= 1'b1;
            state  <= DONE;
          end else if (cardCount3 < 3'd2) begin
            // Never stand on a single card, even a soft 11.
            cardReq <= 1'b1;
            state   <= REQ;
          end else if (bestNow >= standAt6) begin
            stand  <= 1'b1;
            finish <= 1'b1;
            state  <= DONE;
          end else if (cardCount3 == maxCards3) begin
            finish <= 1'b1;
            state  <= DONE;
          end else begin
            cardReq <= 1'b1;
            state   <= REQ;
          end
        end

        DONE: begin
          cardReq <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_player_agent.sv
// tb_card_player_agent
//   Directed bench for card_player_agent. A hand model (list of accepted
//   ranks plus the edge numbers at which the ack, the hand update and the
//   verdict are due) predicts every output; a compare process checks all
//   outputs against it on each falling edge. Literal expectations after each
//   hand pin the model to hand-computed totals and verdicts.

module tb_card_player_agent;

  localparam int STAND_AT  = 17;
  localparam int MAX_CARDS = 5;

  logic       clock;
  logic       reset;
  logic       new_Game;
  logic       cardReady;
  logic [3:0] cardValue4;
  logic [1:0] color2;
  logic       cardReq;
  logic       cardAck;
  logic       badCard;
  logic [4:0] totalValue5;
  logic [2:0] cardCount3;
  logic [1:0] lastColor2;
  logic       finish;
  logic       stand;
  logic       bust;

  card_player_agent #(
    .STAND_AT (STAND_AT),
    .MAX_CARDS(MAX_CARDS)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .new_Game   (new_Game),
    .cardReady  (cardReady),
    .cardValue4 (cardValue4),
    .color2     (color2),
    .cardReq    (cardReq),
    .cardAck    (cardAck),
    .badCard    (badCard),
    .totalValue5(totalValue5),
    .cardCount3 (cardCount3),
    .lastColor2 (lastColor2),
    .finish     (finish),
    .stand      (stand),
    .bust       (bust)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lastXfer    = 0;
  bit checking    = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- hand model ----------------
  int         hand[$];
  logic       expReq, expAck, expBad, expFin, expStand, expBust;
  logic [1:0] expColor;
  int         mcyc, addAt, decideAt;
  int         pendRank;
  logic [1:0] pendSuit;
  int         verdictBest;

  function automatic bit validRank(input int r);
    return (r >= 1) && (r <= 13);
  endfunction

  function automatic int handBest();
    int  s   = 0;
    bit  ace = 1'b0;
    foreach (hand[i]) begin
      s += (hand[i] > 10) ? 10 : hand[i];
      if (hand[i] == 1) ace = 1'b1;
    end
    if (ace && (s + 10 <= 21)) s += 10;
    return s;
  endfunction

  initial begin
    expReq = 0; expAck = 0; expBad = 0; expFin = 0; expStand = 0; expBust = 0;
    expColor = 0; mcyc = 0; addAt = -1; decideAt = -1; pendRank = 0; pendSuit = 0;
  end

  always @(posedge clock or posedge reset) begin
    mcyc = mcyc + 1;
    if (reset || new_Game) begin
      hand.delete();
      expAck = 0; expBad = 0; expFin = 0; expStand = 0; expBust = 0;
      addAt = -1; decideAt = -1;
      expReq = reset ? 1'b0 : 1'b1;
      if (reset) expColor = 0;
    end else begin
      expAck = 0;
      expBad = 0;
      if (mcyc == addAt) begin
        addAt = -1;
        if (validRank(pendRank)) begin
          hand.push_back(pendRank);
          expColor = pendSuit;
          decideAt = mcyc + 1;
        end else begin
          expReq = 1;
        end
      end else if (mcyc == decideAt) begin
        decideAt    = -1;
        verdictBest = handBest();
        if (verdictBest > 21) begin
          expBust = 1; expFin = 1;
        end else if (hand.size() < 2) begin
          expReq = 1;
        end else if (verdictBest >= STAND_AT) begin
          expStand = 1; expFin = 1;
        end else if (hand.size() == MAX_CARDS) begin
          expFin = 1;
        end else begin
          expReq = 1;
        end
      end else if (expReq && cardReady) begin
        expReq   = 0;
        expAck   = 1;
        pendRank = int'(cardValue4);
        pendSuit = color2;
        expBad   = !validRank(pendRank);
        addAt    = mcyc + 1;
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      int b;
      b = handBest();
      chk("cardReq",     32'(cardReq),     32'(expReq));
      chk("cardAck",     32'(cardAck),     32'(expAck));
      chk("badCard",     32'(badCard),     32'(expBad));
      chk("totalValue5", 32'(totalValue5), 32'((b > 31) ? 31 : b));
      chk("cardCount3",  32'(cardCount3),  32'(hand.size()));
      chk("lastColor2",  32'(lastColor2),  32'(expColor));
      chk("finish",      32'(finish),      32'(expFin));
      chk("stand",       32'(stand),       32'(expStand));
      chk("bust",        32'(bust),        32'(expBust));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic startGame();
    new_Game = 1'b1;
    @(negedge clock);
    new_Game = 1'b0;
  endtask

  // Waits (bounded) for cardReq, optionally checks the distance in cycles
  // from the previous handshake cycle, then offers one card for one edge.
  task automatic deal(input logic [3:0] r, input logic [1:0] s, input int expGap);
    int n = 0;
    while (cardReq !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("reqSeen", 32'(cardReq), 32'd1);
    if (cardReq !== 1'b1) return;
    if (expGap != 0) chk("reqGap", 32'(cyc - lastXfer), 32'(expGap));
    cardReady  = 1'b1;
    cardValue4 = r;
    color2     = s;
    lastXfer   = cyc;
    @(negedge clock);
    cardReady  = 1'b0;
    $display("deal rank=%0d suit=%0d ack=%0b bad=%0b", r, s, cardAck, badCard);
  endtask

  task automatic waitFinish();
    int n = 0;
    while (finish !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("finishSeen", 32'(finish), 32'd1);
    $display("hand done total=%0d count=%0d stand=%0b bust=%0b",
             totalValue5, cardCount3, stand, bust);
  endtask

  initial begin
    reset = 1'b0; new_Game = 1'b0; cardReady = 1'b0; cardValue4 = 4'd0; color2 = 2'd0;
    #1 reset = 1'b1;
    @(negedge clock);
    checking = 1'b1;
    chk("rstReq",    32'(cardReq),     32'd0);
    chk("rstTotal",  32'(totalValue5), 32'd0);
    chk("rstFinish", 32'(finish),      32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: 10, 7 -> stand at 17
    startGame();
    deal(4'd10, 2'd0, 0);
    deal(4'd7,  2'd1, 3);
    waitFinish();
    chk("t1Total",  32'(totalValue5), 32'd17);
    chk("t1Count",  32'(cardCount3),  32'd2);
    chk("t1Stand",  32'(stand),       32'd1);
    chk("t1Req",    32'(cardReq),     32'd0);
    chk("t1Color",  32'(lastColor2),  32'd1);

    // 2: A, K -> soft 21 stand; then A, 5, K, 5
    startGame();
    deal(4'd1,  2'd2, 0);
    deal(4'd13, 2'd3, 3);
    waitFinish();
    chk("t2aTotal", 32'(totalValue5), 32'd21);
    chk("t2aStand", 32'(stand),       32'd1);
    startGame();
    deal(4'd1, 2'd0, 0);
    deal(4'd5, 2'd1, 3);
    @(negedge clock);
    chk("t2Soft16", 32'(totalValue5), 32'd16);
    deal(4'd13, 2'd2, 3);
    @(negedge clock);
    chk("t2Hard16", 32'(totalValue5), 32'd16);
    deal(4'd5, 2'd3, 3);
    waitFinish();
    chk("t2bTotal", 32'(totalValue5), 32'd21);
    chk("t2bCount", 32'(cardCount3),  32'd4);
    chk("t2bStand", 32'(stand),       32'd1);

    // 3: 10, 6, 9 -> bust at 25
    startGame();
    deal(4'd10, 2'd1, 0);
    deal(4'd6,  2'd2, 3);
    deal(4'd9,  2'd0, 3);
    waitFinish();
    chk("t3Total", 32'(totalValue5), 32'd25);
    chk("t3Bust",  32'(bust),        32'd1);
    chk("t3Stand", 32'(stand),       32'd0);
    chk("t3Count", 32'(cardCount3),  32'd3);

    // 4: five 2s -> card limit
    startGame();
    deal(4'd2, 2'd3, 0);
    for (int i = 0; i < 4; i++) deal(4'd2, 2'(i), 3);
    waitFinish();
    chk("t4Total", 32'(totalValue5), 32'd10);
    chk("t4Count", 32'(cardCount3),  32'd5);
    chk("t4Stand", 32'(stand),       32'd0);
    chk("t4Bust",  32'(bust),        32'd0);

    // 5: invalid ranks 0 and 15
    startGame();
    deal(4'd0, 2'd1, 0);
    chk("t5Bad0", 32'(badCard), 32'd1);
    deal(4'd15, 2'd2, 2);
    chk("t5Bad15", 32'(badCard), 32'd1);
    @(negedge clock);
    chk("t5Count", 32'(cardCount3), 32'd0);
    chk("t5Req",   32'(cardReq),    32'd1);
    chk("t5Color", 32'(lastColor2), 32'd3);

    // 6: new_Game on the same edge as a transfer
    new_Game   = 1'b1;
    cardReady  = 1'b1;
    cardValue4 = 4'd5;
    color2     = 2'd2;
    @(negedge clock);
    new_Game  = 1'b0;
    cardReady = 1'b0;
    chk("t6Ack",   32'(cardAck),    32'd0);
    chk("t6Count", 32'(cardCount3), 32'd0);
    chk("t6Req",   32'(cardReq),    32'd1);

    // 6b: asynchronous reset in the middle of ADD
    deal(4'd9, 2'd1, 0);
    #2 reset = 1'b1;
    #1;
    chk("t6RstAck",   32'(cardAck),     32'd0);
    chk("t6RstReq",   32'(cardReq),     32'd0);
    chk("t6RstTotal", 32'(totalValue5), 32'd0);
    chk("t6RstColor", 32'(lastColor2),  32'd0);
    @(negedge clock);
    reset = 1'b0;

    // After reset the player stays idle even if the dealer offers a card.
    cardReady  = 1'b1;
    cardValue4 = 4'd4;
    repeat (3) @(negedge clock);
    chk("idleReq", 32'(cardReq), 32'd0);
    chk("idleAck", 32'(cardAck), 32'd0);
    cardReady = 1'b0;
    @(negedge clock);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
